// File: rtl/alu_pkg.sv
// Shared ALU control codes and MIPS opcode/funct encodings for the issue stage.
package alu_pkg;

    // ALU control codes driven on aluc
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0100;
    localparam logic [3:0] ALU_AND   = 4'b0001;
    localparam logic [3:0] ALU_OR    = 4'b0101;
    localparam logic [3:0] ALU_XOR   = 4'b0010;
    localparam logic [3:0] ALU_LUI   = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0011;
    localparam logic [3:0] ALU_SRL   = 4'b0111;
    localparam logic [3:0] ALU_SRA   = 4'b1111;
    localparam logic [3:0] ALU_HDIST = 4'b1110;

    // Primary opcodes (inst[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes (inst[5:0])
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_HDIST = 6'b110000;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;

endpackage

// File: rtl/alu_decode.sv
// Combinational instruction decoder: produces ALU code and operand/writeback controls.
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0] inst,
    output logic [3:0]  aluc,
    output logic        shift,   // operand a is the shamt field
    output logic        sext,    // immediate is sign-extended
    output logic        regrt,   // I-type: b is the immediate, rn is rt
    output logic        wreg,
    output logic        m2reg,
    output logic        wmem,
    output logic        illegal
);

    logic [5:0] op;
    logic [5:0] fn;

    assign op = inst[31:26];
    assign fn = inst[5:0];

    // Decode op/funct into controls; anything unrecognised is flagged illegal
    always_comb begin
        aluc    = ALU_ADD;
        shift   = 1'b0;
        sext    = 1'b0;
        regrt   = 1'b0;
        wreg    = 1'b0;
        m2reg   = 1'b0;
        wmem    = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_RTYPE: begin
                wreg = 1'b1;
                case (fn)
                    FN_ADD:   aluc = ALU_ADD;
                    FN_SUB:   aluc = ALU_SUB;
                    FN_AND:   aluc = ALU_AND;
                    FN_OR:    aluc = ALU_OR;
                    FN_XOR:   aluc = ALU_XOR;
                    FN_HDIST: aluc = ALU_HDIST;
                    FN_SLL: begin aluc = ALU_SLL; shift = 1'b1; end
                    FN_SRL: begin aluc = ALU_SRL; shift = 1'b1; end
                    FN_SRA: begin aluc = ALU_SRA; shift = 1'b1; end
                    default: begin wreg = 1'b0; illegal = 1'b1; end
                endcase
            end
            OP_ADDI: begin aluc = ALU_ADD; regrt = 1'b1; sext = 1'b1; wreg = 1'b1; end
            OP_ANDI: begin aluc = ALU_AND; regrt = 1'b1; wreg = 1'b1; end
            OP_ORI:  begin aluc = ALU_OR;  regrt = 1'b1; wreg = 1'b1; end
            OP_XORI: begin aluc = ALU_XOR; regrt = 1'b1; wreg = 1'b1; end
            OP_LUI:  begin aluc = ALU_LUI; regrt = 1'b1; wreg = 1'b1; end
            OP_LW: begin
                aluc = ALU_ADD; regrt = 1'b1; sext = 1'b1; wreg = 1'b1; m2reg = 1'b1;
            end
            OP_SW: begin
                aluc = ALU_ADD; regrt = 1'b1; sext = 1'b1; wmem = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// ID->EX issue register: operand muxing, valid/ready handshake, flush and issue counter.
module alu_issue
    import alu_pkg::*;
#(
    parameter int ISSUE_CNT_W = 32
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            inst,
    input  logic [31:0]            qa,
    input  logic [31:0]            qb,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            ea,
    output logic [31:0]            eb,
    output logic [3:0]             ealuc,
    output logic                   ewreg,
    output logic                   em2reg,
    output logic                   ewmem,
    output logic [4:0]             ern,
    output logic                   eillegal,
    output logic [ISSUE_CNT_W-1:0] issue_cnt
);

    logic [3:0]  d_aluc;
    logic        d_shift, d_sext, d_regrt, d_wreg, d_m2reg, d_wmem, d_illegal;

    logic [31:0] ea_d, eb_d;
    logic [3:0]  aluc_d;
    logic [4:0]  rn_d;
    logic        wreg_d, m2reg_d, wmem_d;

    logic [31:0] ea_q, eb_q;
    logic [3:0]  aluc_q;
    logic [4:0]  rn_q;
    logic        vld_q, wreg_q, m2reg_q, wmem_q, ill_q;
    logic [ISSUE_CNT_W-1:0] cnt_q;

    logic        load;

    alu_decode u_dec (
        .inst    (inst),
        .aluc    (d_aluc),
        .shift   (d_shift),
        .sext    (d_sext),
        .regrt   (d_regrt),
        .wreg    (d_wreg),
        .m2reg   (d_m2reg),
        .wmem    (d_wmem),
        .illegal (d_illegal)
    );

    assign in_ready = !vld_q | out_ready;
    assign load     = in_valid & in_ready;

    // Operand muxes and writeback controls; an illegal slot issues as all-zero bubble payload
    always_comb begin
        ea_d    = d_shift ? {27'b0, inst[10:6]} : qa;
        eb_d    = d_regrt ? (d_sext ? {{16{inst[15]}}, inst[15:0]} : {16'b0, inst[15:0]}) : qb;
        aluc_d  = d_aluc;
        rn_d    = d_regrt ? inst[20:16] : inst[15:11];
        wreg_d  = d_wreg & (rn_d != 5'd0);
        m2reg_d = d_m2reg;
        wmem_d  = d_wmem;
        if (d_illegal) begin
            ea_d    = 32'b0;
            eb_d    = 32'b0;
            aluc_d  = ALU_ADD;
            rn_d    = 5'd0;
            wreg_d  = 1'b0;
            m2reg_d = 1'b0;
            wmem_d  = 1'b0;
        end
    end

    // Pipeline register: flush beats load, load beats drain, otherwise hold
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vld_q   <= 1'b0;
            ea_q    <= '0;
            eb_q    <= '0;
            aluc_q  <= '0;
            rn_q    <= '0;
            wreg_q  <= 1'b0;
            m2reg_q <= 1'b0;
            wmem_q  <= 1'b0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (flush) begin
            vld_q   <= 1'b0;
            wreg_q  <= 1'b0;
            m2reg_q <= 1'b0;
            wmem_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else if (load) begin
            vld_q   <= 1'b1;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            aluc_q  <= aluc_d;
            rn_q    <= rn_d;
            wreg_q  <= wreg_d;
            m2reg_q <= m2reg_d;
            wmem_q  <= wmem_d;
            ill_q   <= d_illegal;
            if (!d_illegal) cnt_q <= cnt_q + 1'b1;
        end else if (out_ready) begin
            vld_q   <= 1'b0;
        end
    end

    assign out_valid = vld_q;
    assign ea        = ea_q;
    assign eb        = eb_q;
    assign ealuc     = aluc_q;
    assign ern       = rn_q;
    assign ewreg     = wreg_q;
    assign em2reg    = m2reg_q;
    assign ewmem     = wmem_q;
    assign eillegal  = ill_q;
    assign issue_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue with hand-computed expectations.
module tb_alu_issue;

    logic        clock, resetn;
    logic        in_valid, in_ready;
    logic [31:0] inst, qa, qb;
    logic        flush, out_valid, out_ready;
    logic [31:0] ea, eb;
    logic [3:0]  ealuc;
    logic        ewreg, em2reg, ewmem, eillegal;
    logic [4:0]  ern;
    logic [31:0] issue_cnt;

    int n_checks = 0;
    int n_errors = 0;

    alu_issue #(.ISSUE_CNT_W(32)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst      (inst),
        .qa        (qa),
        .qb        (qb),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ea        (ea),
        .eb        (eb),
        .ealuc     (ealuc),
        .ewreg     (ewreg),
        .em2reg    (em2reg),
        .ewmem     (ewmem),
        .ern       (ern),
        .eillegal  (eillegal),
        .issue_cnt (issue_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one instruction for a single edge, sample #1 after it
    task automatic issue(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        inst = i; qa = a; qb = b; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clock); #1;
    endtask

    initial begin
        resetn = 1'b0; in_valid = 1'b0; inst = '0; qa = '0; qb = '0;
        flush = 1'b0; out_ready = 1'b1;
        repeat (2) step();
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_ea",    ea, 32'd0);
        chk("rst_ctl",   {24'b0, ealuc, ewreg, em2reg, ewmem, eillegal}, 32'd0);
        chk("rst_cnt",   issue_cnt, 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        resetn = 1'b1;
        step();

        // add $3,$1,$2
        issue(32'h00221820, 32'd5, 32'd7);
        chk("add_valid", {31'b0, out_valid}, 32'd1);
        chk("add_ea",    ea, 32'd5);
        chk("add_eb",    eb, 32'd7);
        chk("add_aluc",  {28'b0, ealuc}, 32'h0);
        chk("add_rn",    {27'b0, ern}, 32'd3);
        chk("add_wreg",  {31'b0, ewreg}, 32'd1);
        chk("add_cnt",   issue_cnt, 32'd1);

        // sra $4,$2,4
        issue(32'h00022103, 32'h11111111, 32'h80000000);
        chk("sra_ea",    ea, 32'd4);
        chk("sra_eb",    eb, 32'h80000000);
        chk("sra_aluc",  {28'b0, ealuc}, 32'hF);
        chk("sra_rn",    {27'b0, ern}, 32'd4);

        // addi $5,$0,-1
        issue(32'h2005FFFF, 32'd0, 32'h55555555);
        chk("addi_ea",   ea, 32'd0);
        chk("addi_eb",   eb, 32'hFFFFFFFF);
        chk("addi_aluc", {28'b0, ealuc}, 32'h0);
        chk("addi_rn",   {27'b0, ern}, 32'd5);

        // andi $6,$1,0xFFFF
        issue(32'h3026FFFF, 32'h12345678, 32'h0);
        chk("andi_ea",   ea, 32'h12345678);
        chk("andi_eb",   eb, 32'h0000FFFF);
        chk("andi_aluc", {28'b0, ealuc}, 32'h1);

        // sw $7,4($1)
        issue(32'hAC270004, 32'h100, 32'hDEAD);
        chk("sw_ctl",    {29'b0, ewreg, em2reg, ewmem}, 32'b001);
        chk("sw_eb",     eb, 32'd4);

        // lw $8,-4($1)
        issue(32'h8C28FFFC, 32'h200, 32'h0);
        chk("lw_ctl",    {29'b0, ewreg, em2reg, ewmem}, 32'b110);
        chk("lw_eb",     eb, 32'hFFFFFFFC);

        // lui $9,0x1234
        issue(32'h3C091234, 32'h0, 32'h0);
        chk("lui_aluc",  {28'b0, ealuc}, 32'h6);
        chk("lui_eb",    eb, 32'h00001234);
        chk("lui_cnt",   issue_cnt, 32'd7);

        // hdist $10,$1,$2 then backpressure with or $11,$1,$2 pending
        issue(32'h00225030, 32'hA, 32'hB);
        chk("hd_aluc",   {28'b0, ealuc}, 32'hE);
        out_ready = 1'b0;
        inst = 32'h00225825; qa = 32'hC0; qb = 32'hD0; in_valid = 1'b1;
        #1;
        chk("bp_ready0", {31'b0, in_ready}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_hold_ea",  ea, 32'hA);
            chk("bp_hold_rn",  {27'b0, ern}, 32'd10);
            chk("bp_ready",    {31'b0, in_ready}, 32'd0);
        end
        chk("bp_cnt",    issue_cnt, 32'd8);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("bp_ld_ea",  ea, 32'hC0);
        chk("bp_ld_aluc",{28'b0, ealuc}, 32'h5);
        chk("bp_ld_rn",  {27'b0, ern}, 32'd11);
        chk("bp_cnt2",   issue_cnt, 32'd9);

        // flush with in_valid and out_valid high, under backpressure
        out_ready = 1'b0;
        inst = 32'h00221820; qa = 32'h77; qb = 32'h88; in_valid = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("fl_valid",  {31'b0, out_valid}, 32'd0);
        chk("fl_wreg",   {31'b0, ewreg}, 32'd0);
        chk("fl_cnt",    issue_cnt, 32'd9);

        // illegal opcode 111111
        issue(32'hFC221820, 32'h33, 32'h44);
        chk("ill_valid", {31'b0, out_valid}, 32'd1);
        chk("ill_flag",  {31'b0, eillegal}, 32'd1);
        chk("ill_wreg",  {31'b0, ewreg}, 32'd0);
        chk("ill_aluc",  {28'b0, ealuc}, 32'h0);
        chk("ill_ea",    ea, 32'd0);
        chk("ill_cnt",   issue_cnt, 32'd9);

        // add $0,$1,$2: legal, but no register write
        issue(32'h00220020, 32'd1, 32'd2);
        chk("r0_wreg",   {31'b0, ewreg}, 32'd0);
        chk("r0_ill",    {31'b0, eillegal}, 32'd0);
        chk("r0_cnt",    issue_cnt, 32'd10);

        // drain: no input, EX consumes
        step();
        chk("drain_vld", {31'b0, out_valid}, 32'd0);

        // asynchronous reset mid-operation
        issue(32'h00221820, 32'd5, 32'd7);
        #2 resetn = 1'b0;
        #1;
        chk("arst_vld",  {31'b0, out_valid}, 32'd0);
        chk("arst_cnt",  issue_cnt, 32'd0);
        chk("arst_ea",   ea, 32'd0);
        resetn = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
